// File: rtl/gzip_axis_out_bridge.sv
// gzip_axis_out_bridge
//   Drains the compression core's output FIFO into an AXI4-Stream master.
//   A 3-entry holding buffer sits between the FIFO and the stream. One word
//   is always held back until the end of the stream is known, so that TLAST
//   and the partial TKEEP of the final word are correct when it is presented.
//
// Ports
//   core_clock     sole clock
//   bus_reset      synchronous, active-high reset
//   fifo_empty     core output FIFO empty
//   fifo_rden      FIFO read enable (combinational)
//   fifo_data      FIFO read data, valid the cycle after fifo_rden
//   stream_done    one-cycle pulse: the core has written its final word
//   last_bytes     valid bytes in the final word (0 = all), taken with stream_done
//   m_axis_*       AXI4-Stream master (tdata/tvalid/tready/tlast/tkeep)
//   word_count     beats accepted so far in the current stream (saturating)
//
// Build option
//   GZIP_OUT_BSWAP_EN  byte-reverse tdata and mirror the partial tkeep so the
//                      valid bytes of a short final word sit in the high lanes.

module gzip_axis_out_bridge #(
    parameter  int DATA_W = 32,
    localparam int KEEP_W = DATA_W / 8,
    localparam int LB_W   = $clog2(KEEP_W)
) (
    input  logic              core_clock,
    input  logic              bus_reset,
    input  logic              fifo_empty,
    output logic              fifo_rden,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              stream_done,
    input  logic [LB_W-1:0]   last_bytes,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic [31:0]       word_count
);

    // Byte ordering between the FIFO and the stream.
    function automatic logic [DATA_W-1:0] byte_order(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
`ifdef GZIP_OUT_BSWAP_EN
        for (int i = 0; i < KEEP_W; i++) begin
            r[8*i +: 8] = d[8*(KEEP_W-1-i) +: 8];
        end
`else
        r = d;
`endif
        return r;
    endfunction

    // Holding buffer, entry 0 is the head. Data entries carry no reset.
    logic [DATA_W-1:0] buf_q [3];
    logic [DATA_W-1:0] buf_d [3];
    logic [1:0]        cnt_q, cnt_d;
    logic              inflight_q;
    logic              armed_q, armed_d;
    logic [LB_W-1:0]   last_bytes_q, last_bytes_d;
    logic [31:0]       word_count_q, word_count_d;

    logic              drained;
    logic              tvalid_c;
    logic              tlast_c;
    logic              pop;
    logic              end_stream;
    logic [1:0]        wr_idx;
    logic [2:0]        occ_after;
    logic [KEEP_W-1:0] keep_c;

    // Stream handshake and FIFO read decision
    always_comb begin
        drained  = armed_q & fifo_empty & ~inflight_q;
        // Outputs are forced idle during the reset cycle itself, before the
        // registers have had an edge to clear.
        tvalid_c = ~bus_reset & ((cnt_q >= 2'd2) | (drained & (cnt_q == 2'd1)));
        tlast_c  = ~bus_reset & drained & (cnt_q == 2'd1);
        pop      = tvalid_c & m_axis_tready;
        // Occupancy once the outstanding read lands and this cycle's pop
        // leaves; the sum of cnt and inflight never exceeds 3.
        occ_after = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rden = ~fifo_empty & ~bus_reset & (occ_after < 3'd3);
    end

    // Buffer next state: shift on pop, append returning read data behind
    // whatever remains.
    always_comb begin
        buf_d  = buf_q;
        wr_idx = cnt_q - {1'b0, pop};
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
        end
        for (int i = 0; i < 3; i++) begin
            if (inflight_q && (wr_idx == 2'(i))) begin
                buf_d[i] = fifo_data;
            end
        end
        cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    // Stream bookkeeping: arming, final-word byte count, beat counter
    always_comb begin
        armed_d      = armed_q;
        last_bytes_d = last_bytes_q;
        word_count_d = word_count_q;
        // A stream ends either with its tlast beat or, for an empty stream,
        // when the FIFO drains with nothing buffered.
        end_stream   = (pop & tlast_c) | (drained & (cnt_q == 2'd0));
        if (end_stream) begin
            armed_d      = 1'b0;
            word_count_d = '0;
        end else if (pop && (word_count_q != 32'hFFFF_FFFF)) begin
            word_count_d = word_count_q + 32'd1;
        end
        // A done pulse is accepted when idle, or when it coincides with the
        // end of the previous stream.
        if (stream_done && (!armed_q || end_stream)) begin
            armed_d      = 1'b1;
            last_bytes_d = last_bytes;
        end
    end

    // Partial keep on the final beat only
    always_comb begin
        keep_c = '1;
        if (tlast_c && (last_bytes_q != '0)) begin
            for (int i = 0; i < KEEP_W; i++) begin
`ifdef GZIP_OUT_BSWAP_EN
                keep_c[KEEP_W-1-i] = (LB_W'(i) < last_bytes_q);
`else
                keep_c[i] = (LB_W'(i) < last_bytes_q);
`endif
            end
        end
    end

    // Control registers
    always_ff @(posedge core_clock) begin
        if (bus_reset) begin
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            armed_q      <= 1'b0;
            last_bytes_q <= '0;
            word_count_q <= '0;
        end else begin
            cnt_q        <= cnt_d;
            inflight_q   <= fifo_rden;
            armed_q      <= armed_d;
            last_bytes_q <= last_bytes_d;
            word_count_q <= word_count_d;
        end
    end

    // Data registers
    always_ff @(posedge core_clock) begin
        for (int i = 0; i < 3; i++) begin
            buf_q[i] <= buf_d[i];
        end
    end

    // An empty buffer shows zero data so the bus is quiet after reset.
    assign m_axis_tdata  = (bus_reset || (cnt_q == 2'd0)) ? '0 : byte_order(buf_q[0]);
    assign m_axis_tvalid = tvalid_c;
    assign m_axis_tlast  = tlast_c;
    assign m_axis_tkeep  = keep_c;
    assign word_count    = word_count_q;

endmodule

// File: tb/tb_gzip_axis_out_bridge.sv
// Testbench for gzip_axis_out_bridge (DATA_W = 32).
// The core FIFO is modelled as a queue with one-cycle read latency. Every
// word written into it is also placed in an expected-beat list, so the stream
// must reproduce the words in order, with tlast/tkeep only on the final word.

module tb_gzip_axis_out_bridge;

    localparam int DATA_W = 32;

    logic              core_clock = 1'b0;
    logic              bus_reset;
    logic              fifo_empty;
    logic              fifo_rden;
    logic [DATA_W-1:0] fifo_data;
    logic              stream_done;
    logic [1:0]        last_bytes;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic [3:0]        m_axis_tkeep;
    logic [31:0]       word_count;

    gzip_axis_out_bridge #(.DATA_W(DATA_W)) dut (
        .core_clock    (core_clock),
        .bus_reset     (bus_reset),
        .fifo_empty    (fifo_empty),
        .fifo_rden     (fifo_rden),
        .fifo_data     (fifo_data),
        .stream_done   (stream_done),
        .last_bytes    (last_bytes),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .word_count    (word_count)
    );

    always #5 core_clock = ~core_clock;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } beat_t;

    logic [31:0] src_q [$];
    beat_t       exp_q [$];

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    int wc_model = 0;
    int pops, first_valid_cyc, first_rden_cyc, last_pop_cyc;
    int rdy_mode = 0;
    int rdy_tog  = 0;
    logic        post_rst = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [3:0]  prev_keep;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef GZIP_OUT_BSWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    function automatic logic [3:0] exp_keep(input logic last, input logic [1:0] lb);
        logic [3:0] k;
        k = 4'hF;
        if (last && lb != 2'd0) begin
            k = 4'((1 << lb) - 1);
`ifdef GZIP_OUT_BSWAP_EN
            k = {k[0], k[1], k[2], k[3]};
`endif
        end
        return k;
    endfunction

    task automatic add_word(input logic [31:0] d, input logic last, input logic [1:0] lb);
        beat_t b;
        src_q.push_back(d);
        fifo_empty = 1'b0;
        b.data = exp_data(d);
        b.last = last;
        b.keep = exp_keep(last, lb);
        exp_q.push_back(b);
    endtask

    task automatic clr_stats();
        pops = 0;
        first_valid_cyc = -1;
        first_rden_cyc  = -1;
        last_pop_cyc    = -1;
    endtask

    task automatic set_rdy();
        case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: begin m_axis_tready = rdy_tog[0]; rdy_tog++; end
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // One clock: check outputs at the falling edge, then model the FIFO read.
    task automatic tick();
        beat_t e;
        logic  rden_s;
        @(negedge core_clock);
        cyc++;
        rden_s = 1'b0;
        if (bus_reset) begin
            chk("rst_rden",   {63'd0, fifo_rden},     64'd0);
            chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
            chk("rst_tlast",  {63'd0, m_axis_tlast},  64'd0);
            chk("rst_tdata",  {32'd0, m_axis_tdata},  64'd0);
            chk("rst_tkeep",  {60'd0, m_axis_tkeep},  64'hF);
            stall_prev = 1'b0;
        end else begin
            if (post_rst) begin
                chk("post_rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
                chk("post_rst_tdata",  {32'd0, m_axis_tdata},  64'd0);
                chk("post_rst_tkeep",  {60'd0, m_axis_tkeep},  64'hF);
                post_rst = 1'b0;
            end
            chk("word_count", {32'd0, word_count}, 64'(wc_model));
            chk("overread", {63'd0, fifo_rden & fifo_empty}, 64'd0);
            if (fifo_rden && first_rden_cyc < 0) first_rden_cyc = cyc;
            rden_s = fifo_rden;
            if (stall_prev) begin
                chk("stall_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                chk("stall_tdata",  {32'd0, m_axis_tdata},  {32'd0, prev_data});
                chk("stall_tlast",  {63'd0, m_axis_tlast},  {63'd0, prev_last});
                chk("stall_tkeep",  {60'd0, m_axis_tkeep},  {60'd0, prev_keep});
            end
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {63'd0, m_axis_tvalid}, 64'd0);
            end else if (m_axis_tvalid) begin
                e = exp_q[0];
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                chk("tdata", {32'd0, m_axis_tdata}, {32'd0, e.data});
                chk("tlast", {63'd0, m_axis_tlast}, {63'd0, e.last});
                chk("tkeep", {60'd0, m_axis_tkeep}, {60'd0, e.keep});
                if (m_axis_tready) begin
                    void'(exp_q.pop_front());
                    pops++;
                    last_pop_cyc = cyc;
                    wc_model = e.last ? 0 : wc_model + 1;
                end
            end
            stall_prev = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_keep  = m_axis_tkeep;
        end
        @(posedge core_clock);
        #1;
        if (rden_s && src_q.size() != 0) fifo_data = src_q.pop_front();
        fifo_empty  = (src_q.size() == 0);
        stream_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            set_rdy();
            tick();
        end
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input int cycles);
        bus_reset = 1'b1;
        src_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;
        wc_model = 0;
        for (int i = 0; i < cycles; i++) tick();
        bus_reset = 1'b0;
        post_rst  = 1'b1;
    endtask

    initial begin
        int n;
        logic [1:0] lb;
        bus_reset     = 1'b1;
        fifo_empty    = 1'b1;
        fifo_data     = '0;
        stream_done   = 1'b0;
        last_bytes    = 2'd0;
        m_axis_tready = 1'b1;
        clr_stats();

        // Reset with data waiting in the FIFO: no reads may be issued.
        src_q.push_back(32'hDEAD_BEEF);
        fifo_empty = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        do_reset(1);
        tick();

        // Five words, full final word, ready held high.
        clr_stats();
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) add_word(32'hA000_0000 + i, i == 4, 2'd0);
        stream_done = 1'b1;
        last_bytes  = 2'd0;
        tick();
        wait_drain(50);
        tick();
        tick();
        chk("five_pops", 64'(pops), 64'd5);
        chk("five_consecutive", 64'(last_pop_cyc - first_valid_cyc), 64'd4);

        // 100 words, ready high: one beat per cycle after the first.
        clr_stats();
        lb = 2'($urandom_range(0, 3));
        for (int i = 0; i < 100; i++) add_word($urandom, i == 99, lb);
        stream_done = 1'b1;
        last_bytes  = lb;
        tick();
        wait_drain(300);
        chk("tput_pops", 64'(pops), 64'd100);
        chk("tput_no_bubble", 64'(last_pop_cyc - first_valid_cyc), 64'd99);
        // Two edges after the edge that registers the first read.
        chk("first_latency", 64'(first_valid_cyc - (first_rden_cyc + 1)), 64'd2);

        // Backpressure: ready alternates.
        clr_stats();
        rdy_mode = 1;
        rdy_tog  = 0;
        for (int i = 0; i < 20; i++) add_word($urandom, i == 19, 2'd2);
        stream_done = 1'b1;
        last_bytes  = 2'd2;
        set_rdy();
        tick();
        wait_drain(200);
        chk("bp_pops", 64'(pops), 64'd20);

        // Partial tail: single word, three valid bytes.
        clr_stats();
        rdy_mode = 0;
        add_word(32'h1122_3344, 1'b1, 2'd3);
        stream_done = 1'b1;
        last_bytes  = 2'd3;
        tick();
        wait_drain(20);
        chk("tail_pops", 64'(pops), 64'd1);

        // Empty stream: no beat, and the bridge must disarm.
        clr_stats();
        stream_done = 1'b1;
        last_bytes  = 2'd1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        add_word(32'h5566_7788, 1'b1, 2'd0);
        for (int i = 0; i < 6; i++) tick();
        chk("empty_disarmed", 64'(pops), 64'd0);
        stream_done = 1'b1;
        last_bytes  = 2'd0;
        tick();
        wait_drain(20);
        chk("after_empty_pops", 64'(pops), 64'd1);

        // Randomized streams: words trickle in, ready is random.
        rdy_mode = 2;
        for (int s = 0; s < 6; s++) begin
            clr_stats();
            n  = $urandom_range(1, 12);
            lb = 2'($urandom_range(0, 3));
            for (int k = 0; k < n; ) begin
                if ($urandom_range(0, 1) == 1) begin
                    add_word($urandom, k == n - 1, lb);
                    k++;
                end
                set_rdy();
                tick();
            end
            for (int d = $urandom_range(0, 3); d > 0; d--) begin
                set_rdy();
                tick();
            end
            stream_done = 1'b1;
            last_bytes  = lb;
            set_rdy();
            tick();
            wait_drain(200);
            chk("rand_pops", 64'(pops), 64'(n));
        end

        // Reset after three of eight beats: nothing further may appear.
        clr_stats();
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) add_word(32'hC000_0000 + i, i == 7, 2'd0);
        stream_done = 1'b1;
        last_bytes  = 2'd0;
        for (int i = 0; i < 30 && pops < 3; i++) tick();
        chk("mid_pops_before_reset", 64'(pops), 64'd3);
        do_reset(1);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_pops_after_reset", 64'(pops), 64'd3);

        // A fresh stream after the mid-stream reset comes out clean.
        clr_stats();
        add_word(32'h0BAD_F00D, 1'b0, 2'd0);
        add_word(32'h600D_CAFE, 1'b1, 2'd1);
        stream_done = 1'b1;
        last_bytes  = 2'd1;
        tick();
        wait_drain(20);
        tick();
        chk("fresh_pops", 64'(pops), 64'd2);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/gzip_axis_out_bridge.md
GZIP_AXIS_OUT_BRIDGE -- requirements
Module: gzip_axis_out_bridge

Interface
REQ-001 Parameter DATA_W, default 32: stream and FIFO data width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Derived localparams SHALL be KEEP_W = DATA_W/8 and LB_W = clog2(KEEP_W).
REQ-003 Ports SHALL be, in order:
- core_clock  in  1  sole clock.
- bus_reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  core output FIFO empty.
- fifo_rden  out  1  FIFO read enable.
- fifo_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rden.
- stream_done  in  1  single-cycle pulse: core has written its final word.
- last_bytes  in  LB_W  valid bytes in the final word, sampled with stream_done; 0 means all bytes are valid.
- m_axis_tdata  out  DATA_W
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- m_axis_tkeep  out  KEEP_W
- word_count  out  32  beats accepted in the current stream.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named core_clock and bus_reset.

Function
REQ-005 The block SHALL contain a 3-entry FIFO-ordered holding buffer with occupancy cnt (0..3) and an inflight flag, where inflight is fifo_rden registered.
REQ-006 The buffer SHALL write fifo_data the cycle after fifo_rden.
REQ-007 Let pop = m_axis_tvalid & m_axis_tready. fifo_rden SHALL be combinational and equal to ~fifo_empty & ~bus_reset & (cnt + inflight - pop < 3).
REQ-008 Let drained = armed & fifo_empty & ~inflight. m_axis_tvalid SHALL equal (cnt >= 2) | (drained & cnt == 1). One word is held back so tlast is known before it is presented.
REQ-009 m_axis_tdata SHALL be the buffer head entry. m_axis_tlast SHALL equal drained & cnt == 1.
REQ-010 m_axis_tkeep SHALL be all ones, except on a tlast beat with last_bytes_q != 0, where only the low last_bytes_q lanes SHALL be set.
REQ-011 Once tvalid is asserted, tdata, tlast and tkeep SHALL stay stable until pop.
REQ-012 With tready held high, the bridge SHALL sustain 1 beat per cycle. Latency from the first fifo_rden to the first tvalid SHALL be 2 cycles when a second word is available.
REQ-013 A simultaneous buffer write and pop in one cycle SHALL leave cnt unchanged.
REQ-014 stream_done SHALL set armed and capture last_bytes_q. A stream_done pulse while already armed SHALL be ignored.
REQ-015 A pop with tlast SHALL clear armed and clear word_count on the next cycle.
REQ-016 If drained with cnt == 0 (an empty stream), armed SHALL clear, no beat SHALL be emitted, and word_count SHALL clear.
REQ-017 Every other pop SHALL increment word_count, which SHALL saturate at 32'hFFFFFFFF.
REQ-018 A stream_done pulse in the same cycle as a tlast pop SHALL arm the next stream.

Reset
REQ-019 bus_reset SHALL clear cnt, inflight, armed, last_bytes_q and word_count.
REQ-020 Data returning for an inflight read at reset SHALL be discarded.
REQ-021 During and after reset: fifo_rden = 0, m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tkeep = all ones.
REQ-022 Reset asserted mid-stream SHALL drop all buffered words with no tlast emitted.

Configuration
REQ-023 Macro GZIP_OUT_BSWAP_EN, when defined, SHALL reverse the byte order of m_axis_tdata relative to fifo_data, and SHALL mirror m_axis_tkeep so the valid bytes of a partial last word occupy the high lanes.
REQ-024 Without GZIP_OUT_BSWAP_EN, bytes SHALL pass in native order and the partial tkeep SHALL occupy the low lanes.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset: 5 words preloaded, stream_done, last_bytes=0, tready=1 -> 5 consecutive beats, tkeep=4'hF, tlast only on beat 5, word_count=4 during beat 5, then 0.
- Throughput: 100 words with tready=1 -> 100 beats in 100 consecutive cycles once the first is valid, no bubbles.
- Backpressure: tready toggles 1010... -> tdata/tlast/tkeep stable during stall cycles, order preserved, no FIFO overread.
- Partial tail: 1 word 32'h11223344, last_bytes=3 -> one beat, tlast=1, tkeep=4'b0111; with GZIP_OUT_BSWAP_EN -> tdata=32'h44332211, tkeep=4'b1110.
- Empty stream: stream_done with FIFO empty and buffer empty -> no beat, armed clears.
- Reset mid-stream: bus_reset after 3 of 8 words -> tvalid=0 next cycle, word_count=0, no tlast.
